encoder_32to5_q: RTL and testbench

Registered 32-to-5 request encoder with a valid/ready output handshake, the inverse of the 5-to-32 select decoder. It collects up to 32 single-cycle request pulses into a sticky pending set and emits one 5-bit index per accepted handshake. It sits between event or select sources (register-write strobes, interrupt lines) and a consumer that processes one indexed item at a time.

---
 rtl/encoder_32to5_q.sv | 122 ++++++++++++
 tb/tb_encoder_32to5_q.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_32to5_q.sv
// encoder_32to5_q: registered 32-to-5 request encoder with a valid/ready output.
// Request pulses accumulate in a sticky pending set. One index is presented at a
// time and is held until the consumer accepts it.
// Optional feature: define ENC_ROUND_ROBIN_EN for round-robin selection.
// Without it, the lowest set index always wins.
module encoder_32to5_q (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req,
  input  logic        flush,
  input  logic        ready,
  output logic [4:0]  idx,
  output logic        valid,
  output logic [31:0] pend,
  output logic [5:0]  count
);

  logic        hs;
  logic        load;
  logic [31:0] clr;
  logic [31:0] pend_next;
  logic [31:0] cand;
  logic [5:0]  count_next;
  logic [4:0]  sel_idx;
  logic        sel_found;

`ifdef ENC_ROUND_ROBIN_EN
  logic [4:0]  last;
  logic [4:0]  ptr;
  logic [4:0]  k;
`endif

  // Next pending set. A new request beats the clear of the index being accepted.
  // The accepted index is excluded from the candidates for the next load, so a
  // re-requested index is presented again later rather than back to back.
  always_comb begin
    hs        = valid & ready;
    clr       = hs ? (32'd1 << idx) : 32'd0;
    pend_next = (pend & ~clr) | req;
    load      = ~valid | hs;
    cand      = pend_next & ~clr;
  end

  // Population count of the next pending set. It is registered together with pend.
  always_comb begin
    count_next = 6'd0;
    for (int i = 0; i < 32; i++) begin
      count_next = count_next + 6'(pend_next[i]);
    end
  end

`ifdef ENC_ROUND_ROBIN_EN
  // Round-robin pick. The search starts just after the most recently accepted index.
  // On a handshake, that index is the one being accepted in this cycle.
  always_comb begin
    sel_idx   = 5'd0;
    sel_found = 1'b0;
    k         = 5'd0;
    ptr       = hs ? idx : last;
    for (int i = 0; i < 32; i++) begin
      k = ptr + 5'(i) + 5'd1;
      if (!sel_found && cand[k]) begin
        sel_idx   = k;
        sel_found = 1'b1;
      end
    end
  end

  // Pointer to the last accepted index. Its reset value makes the first search start at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 5'd31;
    end else if (flush) begin
      last <= 5'd31;
    end else if (hs) begin
      last <= idx;
    end
  end
`else
  // Fixed priority. Scanning downward lets the lowest set index be the last one written.
  always_comb begin
    sel_idx   = 5'd0;
    sel_found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (cand[i]) begin
        sel_idx   = 5'(i);
        sel_found = 1'b1;
      end
    end
  end
`endif

  // Pending set and its count. flush overrides both requests and handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 32'd0;
      count <= 6'd0;
    end else if (flush) begin
      pend  <= 32'd0;
      count <= 6'd0;
    end else begin
      pend  <= pend_next;
      count <= count_next;
    end
  end

  // Output stage. It is frozen while an index waits for ready.
  // It reloads when the stage is empty or when the current index is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      idx   <= 5'd0;
    end else if (flush) begin
      valid <= 1'b0;
      idx   <= 5'd0;
    end else if (load) begin
      valid <= sel_found;
      idx   <= sel_found ? sel_idx : 5'd0;
    end
  end

endmodule

// File: tb/tb_encoder_32to5_q.sv
// Scoreboard bench for encoder_32to5_q.
// The driver runs a set-level reference model and queues the expected state and
// the expected accepted indices. Monitors compare these against the DUT.
module tb_encoder_32to5_q;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req;
  logic        flush;
  logic        ready;
  logic [4:0]  idx;
  logic        valid;
  logic [31:0] pend;
  logic [5:0]  count;

  typedef struct {
    logic [31:0] pend;
    logic [5:0]  count;
    logic        valid;
    logic [4:0]  idx;
  } st_t;

  st_t state_q[$];
  int  hs_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  run    = 1'b0;

  bit [31:0] m_pend;
  bit        m_valid;
  int        m_idx;
  int        m_last;

  encoder_32to5_q dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .flush (flush),
    .ready (ready),
    .idx   (idx),
    .valid (valid),
    .pend  (pend),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns the index the encoder should pick from set s, or -1 if s is empty.
  function automatic int pick(input bit [31:0] s);
`ifdef ENC_ROUND_ROBIN_EN
    for (int i = 1; i <= 32; i++) begin
      if (s[(m_last + i) % 32]) return (m_last + i) % 32;
    end
`else
    for (int i = 0; i < 32; i++) begin
      if (s[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Applies one cycle of inputs, advances the model, and queues the expected results.
  task automatic step(input logic [31:0] r, input logic rd, input logic fl);
    bit        hsm;
    bit [31:0] nxt;
    bit [31:0] c;
    int        p;
    st_t       e;
    @(negedge clk);
    req   = r;
    ready = rd;
    flush = fl;
    if (fl) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_last  = 31;
    end else begin
      hsm = m_valid && rd;
      nxt = m_pend;
      c   = '0;
      if (hsm) begin
        hs_q.push_back(m_idx);
        nxt[m_idx] = 1'b0;
        m_last = m_idx;
      end
      nxt = nxt | r;
      if (!m_valid || hsm) begin
        c = nxt;
        if (hsm) c[m_idx] = 1'b0;
        p = pick(c);
        m_valid = (p >= 0);
        m_idx   = (p >= 0) ? p : 0;
      end
      m_pend = nxt;
    end
    e.pend  = m_pend;
    e.count = 6'($countones(m_pend));
    e.valid = m_valid;
    e.idx   = 5'(m_idx);
    state_q.push_back(e);
  endtask

  // Handshake monitor. It samples in mid-cycle, after the inputs have settled.
  always @(negedge clk) begin
    if (run) begin
      #2;
      if (valid === 1'b1 && ready === 1'b1 && flush === 1'b0) begin
        if (hs_q.size() == 0) chk("hs_unexpected", 32'(idx), 32'hFFFF_FFFF);
        else chk("hs_idx", 32'(idx), 32'(hs_q.pop_front()));
      end
    end
  end

  // State monitor. It samples just after each rising edge.
  always @(posedge clk) begin
    if (run) begin
      #1;
      if (state_q.size() > 0) begin
        st_t e;
        e = state_q.pop_front();
        chk("pend",  pend,         e.pend);
        chk("count", 32'(count),   32'(e.count));
        chk("valid", 32'(valid),   32'(e.valid));
        chk("idx",   32'(idx),     32'(e.idx));
      end
    end
  end

  initial begin
    logic [31:0] r;
    req    = '0;
    ready  = 1'b0;
    flush  = 1'b0;
    rst_n  = 1'b1;
    m_pend = '0; m_valid = 1'b0; m_idx = 0; m_last = 31;

    // Asynchronous reset asserted mid-cycle. Outputs stay cleared while it is held.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pend",  pend,       32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    req = 32'hFFFF_FFFF;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_pend",  pend,        32'd0);
    chk("rst_hold_count", 32'(count),  32'd0);
    chk("rst_hold_idx",   32'(idx),    32'd0);
    chk("rst_hold_valid", 32'(valid),  32'd0);
    @(negedge clk);
    req = '0;
    ready = 1'b0;
    rst_n = 1'b1;
    run = 1'b1;

    // Idle with ready high: nothing is presented.
    repeat (10) step(32'h0, 1'b1, 1'b0);

    // Single request, held for several cycles, then accepted.
    step(32'h0000_0020, 1'b0, 1'b0);
    repeat (5) step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b1, 1'b0);
    repeat (2) step(32'h0, 1'b0, 1'b0);

    // Priority and hold behaviour.
    step(32'h8000_0001, 1'b0, 1'b0);
    step(32'h0000_0001, 1'b0, 1'b0);
    repeat (3) step(32'h0, 1'b1, 1'b0);

    // Set wins over clear in the accepting cycle.
    step(32'h0000_0080, 1'b0, 1'b0);
    step(32'h0000_0080, 1'b1, 1'b0);
    repeat (3) step(32'h0, 1'b1, 1'b0);

    // Scattered bits, followed by a later pair.
    step(32'h4000_0204, 1'b0, 1'b0);
    repeat (2) step(32'h0, 1'b1, 1'b0);
    step(32'h0000_000A, 1'b1, 1'b0);
    repeat (4) step(32'h0, 1'b1, 1'b0);

    // Full set drained with ready held high.
    step(32'hFFFF_FFFF, 1'b1, 1'b0);
    step(32'hFFFF_FFFF, 1'b1, 1'b0);
    repeat (34) step(32'h0, 1'b1, 1'b0);

    // Flush while full and valid. A same-cycle request is discarded.
    step(32'hFFFF_FFFF, 1'b0, 1'b0);
    step(32'h0000_0001, 1'b1, 1'b1);
    repeat (3) step(32'h0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: r = 32'h0;
        3:       r = 32'h1 << $urandom_range(0, 31);
        4:       r = (n % 97 == 0) ? 32'hFFFF_FFFF : $urandom;
        default: r = $urandom & $urandom & $urandom;
      endcase
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
    end
    repeat (3) step(32'h0, 1'b1, 1'b0);

    @(posedge clk);
    #3;
    run = 1'b0;
    chk("leftover_hs",    32'(hs_q.size()),    32'd0);
    chk("leftover_state", 32'(state_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
